// File: rtl/uwasic_spi_pwm_peripheral.sv
// Write-only SPI (mode 0) register block driving 16 outputs, each either off,
// static high, or modulated by one shared ~3 kHz PWM signal.
module uwasic_spi_pwm_peripheral #(
    parameter int PWM_CLK_DIV = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PRE_W = (PWM_CLK_DIV > 1) ? $clog2(PWM_CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_CLK_DIV - 1);

    function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
        return (cnt == 5'd16) ? cnt : cnt + 5'd1;
    endfunction

    logic sclk_p0, sclk_p1, sclk_p2;
    logic copi_p0, copi_p1;
    logic ncs_p0, ncs_p1, ncs_p2;
    logic sclk_rise, ncs_fall, ncs_rise;

    logic        frame_active;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        commit;

    logic [15:0]      en_out;
    logic [15:0]      en_pwm;
    logic [7:0]       pwm_duty;
    logic [PRE_W-1:0] prescaler;
    logic [7:0]       pwm_counter;
    logic             pwm_signal;
    logic [15:0]      out_q;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in[7:3], uio_in};

    // Synchronizers idle nCS at 0 so a reset with nCS held low never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            copi_p0 <= 1'b0;
            copi_p1 <= 1'b0;
            ncs_p0  <= 1'b0;
            ncs_p1  <= 1'b0;
            ncs_p2  <= 1'b0;
        end else begin
            sclk_p0 <= ui_in[0];
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            copi_p0 <= ui_in[1];
            copi_p1 <= copi_p0;
            ncs_p0  <= ui_in[2];
            ncs_p1  <= ncs_p0;
            ncs_p2  <= ncs_p1;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign ncs_fall  = ~ncs_p1 & ncs_p2;
    assign ncs_rise  = ncs_p1 & ~ncs_p2;

    // Frame capture: only bits seen after a genuine nCS fall are shifted in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_active <= 1'b0;
            bit_cnt      <= 5'd0;
            shift_reg    <= 16'h0000;
        end else if (ncs_fall) begin
            frame_active <= 1'b1;
            bit_cnt      <= 5'd0;
            shift_reg    <= 16'h0000;
        end else if (ncs_rise) begin
            frame_active <= 1'b0;
        end else if (frame_active && sclk_rise) begin
            if (bit_cnt != 5'd16) begin
                shift_reg <= {shift_reg[14:0], copi_p1};
            end
            bit_cnt <= sat_inc(bit_cnt);
        end
    end

    assign commit = ncs_rise && frame_active && (bit_cnt == 5'd16) &&
                    shift_reg[15] && (shift_reg[14:8] <= 7'd4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_out   <= 16'h0000;
            en_pwm   <= 16'h0000;
            pwm_duty <= 8'h00;
        end else if (commit) begin
            case (shift_reg[14:8])
                7'd0:    en_out[7:0]  <= shift_reg[7:0];
                7'd1:    en_out[15:8] <= shift_reg[7:0];
                7'd2:    en_pwm[7:0]  <= shift_reg[7:0];
                7'd3:    en_pwm[15:8] <= shift_reg[7:0];
                7'd4:    pwm_duty     <= shift_reg[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler   <= '0;
            pwm_counter <= 8'h00;
        end else if (prescaler == PRE_MAX) begin
            prescaler   <= '0;
            pwm_counter <= pwm_counter + 8'd1;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Duty 0xFF is forced fully on; otherwise counter < duty gives duty/256 high time.
    assign pwm_signal = (pwm_duty == 8'hFF) || (pwm_counter < pwm_duty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= 16'h0000;
        end else begin
            out_q <= en_out & (~en_pwm | {16{pwm_signal}});
        end
    end

    assign uo_out  = out_q[7:0];
    assign uio_out = out_q[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_spi_pwm_peripheral.sv
// Directed bench: SPI register writes, rejected frames, PWM timing and duty extremes.
module tb_uwasic_spi_pwm_peripheral;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       sclk, copi, ncs;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    uwasic_spi_pwm_peripheral #(.PWM_CLK_DIV(13)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] w, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            copi = w[15 - first - k];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nbits);
        ncs = 1'b0;
        wait_clk(4);
        spi_bits(w, 0, nbits);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(8);
    endtask

    task automatic count_high(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c0 += int'(uo_out[0]);
            c1 += int'(uo_out[1]);
        end
    endtask

    task automatic measure(output int hi, output int per);
        int t;
        int lo;
        t  = 0;
        hi = 0;
        lo = 0;
        while (uo_out[0] !== 1'b0 && t < 4000) begin wait_clk(1); t++; end
        while (uo_out[0] !== 1'b1 && t < 8000) begin wait_clk(1); t++; end
        while (uo_out[0] === 1'b1 && hi < 4000) begin wait_clk(1); hi++; end
        while (uo_out[0] === 1'b0 && lo < 4000) begin wait_clk(1); lo++; end
        per = hi + lo;
    endtask

    initial begin
        int c0, c1, hi, per;
        rst_n  = 1'b0;
        ena    = 1'b1;
        sclk   = 1'b0;
        copi   = 1'b0;
        ncs    = 1'b1;
        uio_in = 8'h00;

        wait_clk(5);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'hFF);
        rst_n = 1'b1;
        wait_clk(4);
        chk("idle_uo_out", uo_out, 8'h00);

        spi_frame(16'h80F0, 16);
        chk("wr_en_out_lo", uo_out, 8'hF0);
        spi_frame(16'h8155, 16);
        chk("wr_en_out_hi", uio_out, 8'h55);

        spi_frame(16'h00FF, 16);
        chk("read_ignored_lo", uo_out, 8'hF0);
        chk("read_ignored_hi", uio_out, 8'h55);
        spi_frame(16'hB0AA, 16);
        chk("addr30_ignored_lo", uo_out, 8'hF0);
        chk("addr30_ignored_hi", uio_out, 8'h55);
        spi_frame(16'h85FF, 16);
        chk("addr05_ignored_lo", uo_out, 8'hF0);
        chk("addr05_ignored_hi", uio_out, 8'h55);
        spi_frame(16'h8000, 15);
        chk("short_frame_ignored", uo_out, 8'hF0);

        // 50% duty on out[0]
        spi_frame(16'h8201, 16);
        spi_frame(16'h8480, 16);
        spi_frame(16'h8001, 16);
        chk("static_hi_kept", uio_out, 8'h55);
        measure(hi, per);
        chk("pwm50_period", per, 3328);
        chk("pwm50_high", hi, 1664);
        count_high(3328, c0, c1);
        chk("pwm50_count", c0, 1664);

        spi_frame(16'h8400, 16);
        count_high(6700, c0, c1);
        chk("duty00_const0", c0, 0);
        spi_frame(16'h84FF, 16);
        count_high(6700, c0, c1);
        chk("dutyFF_const1", c0, 6700);

        // Mixed: out[1] static, out[0] at 25%
        spi_frame(16'h8003, 16);
        spi_frame(16'h8100, 16);
        spi_frame(16'h8300, 16);
        spi_frame(16'h8440, 16);
        chk("mixed_uio_out", uio_out, 8'h00);
        count_high(3328, c0, c1);
        chk("mixed_bit0_25pct", c0, 832);
        chk("mixed_bit1_static", c1, 3328);
        measure(hi, per);
        chk("pwm25_high", hi, 832);
        chk("pwm25_period", per, 3328);
        spi_frame(16'h8002, 16);
        count_high(3328, c0, c1);
        chk("cleared_bit0", c0, 0);
        chk("cleared_bit1_static", c1, 3328);

        // Reset in the middle of a frame must abort it
        ncs = 1'b0;
        wait_clk(4);
        spi_bits(16'h80FF, 0, 8);
        rst_n = 1'b0;
        wait_clk(3);
        chk("midreset_uo_out", uo_out, 8'h00);
        rst_n = 1'b1;
        wait_clk(2);
        spi_bits(16'h80FF, 8, 8);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(8);
        chk("aborted_frame_lo", uo_out, 8'h00);
        chk("aborted_frame_hi", uio_out, 8'h00);
        spi_frame(16'h80FF, 16);
        chk("after_abort_write", uo_out, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
